lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/lsu_mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory controller:
// FSM state encoding, RISC-V funct3 width codes and request classification.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Stores only exist in signed-width form; the unsigned codes are load-only.
   function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      ok = 1'b0;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (funct3[1:0])
         2'b00:   be = 4'b0001 << addr_lo;
         2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
      logic [31:0] lanes;
      case (funct3[1:0])
         2'b00:   lanes = {4{wdata[7:0]}};
         2'b01:   lanes = {2{wdata[15:0]}};
         default: lanes = wdata;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed lane of the bus word down to bit 0
// and sign- or zero-extends it according to funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] lane;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (here via the leading defaults), otherwise synthesis infers a latch.
   always_comb begin
      lane   = rdata_i >> {addr_lo_i, 3'b000};
      data_o = lane;
      case (funct3_i)
         F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
         F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   data_o = {24'd0, lane[7:0]};
         F3_HU:   data_o = {16'd0, lane[15:0]};
         default: data_o = lane;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU memory controller: one outstanding request, req/gnt/rvalid bus handshake.
// Optional WAIT-state response timeout is enabled with `define LSU_TIMEOUT_EN.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        busy_o
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic        busy_q, busy_d;
   logic [31:0] load_data;
   logic        req_bad;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   lsu_load_align u_load_align (
      .rdata_i   (mem_rdata_i),
      .addr_lo_i (addr_lo_q),
      .funct3_i  (funct3_q),
      .data_o    (load_data)
   );

   assign req_ready_o = (state_q == ST_IDLE) & rst_ni;
   assign req_bad     = ~funct3_legal(req_we_i, req_funct3_i) |
                        is_misaligned(req_funct3_i, req_addr_i[1:0]);

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && req_ready_o) begin
               we_d      = req_we_i;
               funct3_d  = req_funct3_i;
               addr_lo_d = req_addr_i[1:0];
               if (req_bad) begin
                  // Rejected requests never touch the bus.
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = 32'd0;
               end else begin
                  state_d     = ST_REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we_i;
                  mem_addr_d  = {req_addr_i[31:2], 2'b00};
                  mem_be_d    = byte_enable(req_funct3_i, req_addr_i[1:0]);
                  mem_wdata_d = store_lanes(req_funct3_i, req_wdata_i);
               end
            end
         end
         ST_REQ: begin
            if (mem_gnt_i) begin
               state_d   = ST_WAIT;
               mem_req_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = we_q ? 32'd0 : load_data;
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = 32'd0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_data_d  = 32'd0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // NOTE: flops use non-blocking assignments so every register samples the
   // pre-edge value of every other register, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'd0;
         addr_lo_q   <= 2'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_wdata_q <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_be_o    = mem_be_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: the driver pushes expected bus requests and
// responses from a reference model; a monitor pops and compares them as they appear.
module tb_lsu_mem_ctrl;

   localparam int TB_TIMEOUT = 16;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } rsp_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic        busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   rsp_exp_t rsp_q[$];
   bus_exp_t bus_q[$];

   lsu_mem_ctrl #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_data_o   (rsp_data_o),
      .rsp_err_o    (rsp_err_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (plain arithmetic on the ISA rules) ----------------
   function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      bit legal;
      bit mis;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      mis   = ((f3 % 4) == 1 && (addr % 2) != 0) || ((f3 % 4) == 2 && (addr % 4) != 0);
      return !legal || mis;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      int sh;
      case (f3 % 4)
         0: begin sh = int'(addr % 4); return 4'(1 << sh); end
         1: return (addr % 4) >= 2 ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3 % 4)
         0: return (wd & 32'hFF) * 32'h0101_0101;
         1: return (wd & 32'hFFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rd);
      logic [31:0] v;
      v = rd / (32'd1 << (8 * (addr % 4)));
      case (f3)
         3'd0: return ((v & 32'hFF) >= 32'd128) ? (v & 32'hFF) - 32'd256 : (v & 32'hFF);
         3'd1: return ((v & 32'hFFFF) >= 32'd32768) ? (v & 32'hFFFF) - 32'd65536 : (v & 32'hFFFF);
         3'd4: return v & 32'hFF;
         3'd5: return v & 32'hFFFF;
         default: return v;
      endcase
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      #1;
      if (rst_ni) begin
         if (rsp_valid_o) begin
            if (rsp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_rsp: got data 0x%08h err %0b, expected no response (cycle %0d)",
                        rsp_data_o, rsp_err_o, cyc);
            end else begin
               rsp_exp_t e;
               e = rsp_q.pop_front();
               check("rsp_data", rsp_data_o, e.data);
               check("rsp_err", 32'(rsp_err_o), 32'(e.err));
               check("rsp_cycle", cyc, e.cyc);
               check("ready_in_resp", 32'(req_ready_o), 32'd0);
            end
         end
         if (mem_req_o) begin
            if (bus_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_mem_req: got addr 0x%08h, expected mem_req_o low (cycle %0d)",
                        mem_addr_o, cyc);
            end else begin
               check("mem_we", 32'(mem_we_o), 32'(bus_q[0].we));
               check("mem_addr", mem_addr_o, bus_q[0].addr);
               check("mem_be", 32'(mem_be_o), 32'(bus_q[0].be));
               check("mem_wdata", mem_wdata_o, bus_q[0].wdata);
               check("ready_in_req", 32'(req_ready_o), 32'd0);
               if (mem_gnt_i) void'(bus_q.pop_front());
            end
         end
         check("busy_vs_ready", 32'(busy_o), 32'(!req_ready_o));
      end
   end

   // ---------------- driver ----------------
   task automatic wait_ready();
      int g = 0;
      while (!req_ready_o && g < 64) begin
         @(negedge clk);
         g++;
      end
      check("ready_wait", 32'(req_ready_o), 32'd1);
   endtask

   // rd < 0 means the bus never answers.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int gd, input int rd);
      rsp_exp_t re;
      bus_exp_t be;
      bit err;
      int t;
      wait_ready();
      err = model_err(we, f3, addr);
      t = cyc + 1;
      if (err) begin
         re.data = 32'd0; re.err = 1'b1; re.cyc = t;
      end else begin
         be.we = we; be.addr = addr & 32'hFFFF_FFFC;
         be.be = model_be(f3, addr); be.wdata = model_wdata(f3, wd);
         bus_q.push_back(be);
         if (rd < 0) begin
            re.data = 32'd0; re.err = 1'b1; re.cyc = t + gd + 1 + TB_TIMEOUT;
         end else begin
            re.data = we ? 32'd0 : model_load(f3, addr, rdata);
            re.err = 1'b0; re.cyc = t + gd + rd + 2;
         end
      end
      rsp_q.push_back(re);
      req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
      req_addr_i = addr; req_wdata_i = wd;
      @(negedge clk);
      req_valid_i = 1'b0;
      req_addr_i = $urandom; req_wdata_i = $urandom;
      if (!err) begin
         repeat (gd) begin
            mem_rvalid_i = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
            @(negedge clk);
         end
         mem_rvalid_i = 1'b0;
         mem_gnt_i = 1'b1;
         @(negedge clk);
         mem_gnt_i = 1'b0;
         if (rd >= 0) begin
            repeat (rd) @(negedge clk);
            mem_rvalid_i = 1'b1;
            mem_rdata_i = rdata;
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i = $urandom;
         end
      end
   endtask

   task automatic drain();
      int g = 0;
      while ((rsp_q.size() != 0 || bus_q.size() != 0) && g < 64) begin
         @(negedge clk);
         g++;
      end
      check("drain_rsp_q", rsp_q.size(), 0);
      check("drain_bus_q", bus_q.size(), 0);
      rsp_q.delete();
      bus_q.delete();
   endtask

   task automatic reset_in_wait();
      bus_exp_t be;
      wait_ready();
      be.we = 1'b0; be.addr = 32'h0000_0300; be.be = 4'hF; be.wdata = 32'd0;
      bus_q.push_back(be);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
      req_addr_i = 32'h0000_0300; req_wdata_i = 32'd0;
      @(negedge clk);
      req_valid_i = 1'b0;
      mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      #2;
      check("busy_in_wait", 32'(busy_o), 32'd1);
      rst_ni = 1'b0;
      @(negedge clk);
      #2;
      check("rst_mem_req", 32'(mem_req_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_ready_low", 32'(req_ready_o), 32'd0);
      rst_ni = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 32'h1234_5678;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #2;
      check("ready_after_rst", 32'(req_ready_o), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
      req_addr_i = 32'd0; req_wdata_i = 32'd0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
      repeat (3) @(negedge clk);
      #2;
      check("rst_mem_req0", 32'(mem_req_o), 32'd0);
      check("rst_mem_we0", 32'(mem_we_o), 32'd0);
      check("rst_mem_addr0", mem_addr_o, 32'd0);
      check("rst_mem_be0", 32'(mem_be_o), 32'd0);
      check("rst_mem_wdata0", mem_wdata_o, 32'd0);
      check("rst_rsp_valid0", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_data0", rsp_data_o, 32'd0);
      check("rst_rsp_err0", 32'(rsp_err_o), 32'd0);
      check("rst_busy0", 32'(busy_o), 32'd0);
      check("rst_ready0", 32'(req_ready_o), 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);

      // Directed cases.
      issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0);
      issue(1'b0, 3'b000, 32'h0000_0203, 32'd0, 32'h80FF_1234, 0, 0);
      issue(1'b0, 3'b100, 32'h0000_0203, 32'd0, 32'h80FF_1234, 0, 0);
      issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'd0, 0, 0);
      issue(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'hBEEF_0000, 0, 0);
      issue(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 0, 0);
      issue(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 0, 0);
      issue(1'b1, 3'b100, 32'h0000_0104, 32'd0, 32'd0, 0, 0);
      issue(1'b0, 3'b001, 32'h0000_0207, 32'd0, 32'd0, 0, 0);
      issue(1'b1, 3'b000, 32'h0000_0402, 32'h0000_00A5, 32'd0, 5, 2);
      issue(1'b0, 3'b010, 32'h0000_0408, 32'd0, 32'hCAFE_F00D, 5, 0);
      drain();

      reset_in_wait();
      drain();

`ifdef LSU_TIMEOUT_EN
      issue(1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'd0, 1, -1);
      drain();
      mem_rvalid_i = 1'b1;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #2;
      check("ready_after_timeout", 32'(req_ready_o), 32'd1);
      repeat (3) @(negedge clk);
`endif

      // Randomized traffic, biased towards aligned legal accesses.
      for (int i = 0; i < 120; i++) begin
         logic [2:0] f3;
         logic [31:0] a;
         f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
         a = $urandom;
         if ($urandom_range(0, 2) != 0) a = (f3 % 4 == 2) ? (a & ~32'd3) : ((f3 % 4 == 1) ? (a & ~32'd1) : a);
         issue(1'($urandom), f3, a, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
